// File: rtl/tx_split_pkg.sv
// Field widths, state codes, bus layouts and the keep helper shared by the TX request splitter.
package tx_split_pkg;

  localparam int SESSION_W   = 16;
  localparam int LEN_W       = 32;
  localparam int CHUNK_LEN_W = 16;
  localparam int ERR_W       = 2;
  localparam int BEAT_BYTES  = 64;
  localparam int CNT_W       = 17;
  localparam int BEAT_CNT_W  = 11;
  localparam int RSVD_W      = 64 - ERR_W - LEN_W - SESSION_W;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_META   = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_STATUS = 3'd4;

  typedef struct packed {
    logic [LEN_W-1:0]     len;
    logic [SESSION_W-1:0] session;
  } req_t;

  typedef struct packed {
    logic [CHUNK_LEN_W-1:0] len;
    logic [SESSION_W-1:0]   session;
  } meta_t;

  typedef struct packed {
    logic [ERR_W-1:0]     err;
    logic [RSVD_W-1:0]    rsvd;
    logic [LEN_W-1:0]     len;
    logic [SESSION_W-1:0] session;
  } sts_t;

  // A residue of zero means the final beat is full.
  function automatic logic [BEAT_BYTES-1:0] keep_mask(input logic [5:0] len_mod);
    logic [BEAT_BYTES-1:0] m;
    for (int i = 0; i < BEAT_BYTES; i++) begin
      m[i] = (len_mod == 6'd0) || (i < int'(len_mod));
    end
    return m;
  endfunction

endpackage

// File: rtl/tx_split_status_agg.sv
// Tracks issued vs acknowledged chunks of one request and ORs their error bits.
// Ready is combinational from the counters; counters update on the handshake edge.
module tx_split_status_agg
  import tx_split_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic             issue,
  input  logic             active,
  input  logic             sts_valid,
  input  logic [ERR_W-1:0] sts_err,
  output logic             sts_ready,
  output logic             all_acked,
  output logic [ERR_W-1:0] err
);

  logic [CNT_W-1:0] issued;
  logic [CNT_W-1:0] acked;

  assign sts_ready = active && (acked < issued);
  assign all_acked = (acked == issued);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      issued <= '0;
      acked  <= '0;
      err    <= '0;
    end else if (clear) begin
      issued <= '0;
      acked  <= '0;
      err    <= '0;
    end else begin
      if (issue) begin
        issued <= issued + 1'b1;
      end
      if (sts_valid && sts_ready) begin
        acked <= acked + 1'b1;
        err   <= err | sts_err;
      end
    end
  end

endmodule

// File: rtl/tx_data_split.sv
// Splits one host send request into CHUNK_LEN-sized engine requests and merges their statuses.
// Payload is a zero-latency pass-through during DATA; every channel honours valid/ready backpressure.
module tx_data_split
  import tx_split_pkg::*;
#(
  parameter int CHUNK_LEN = 4096,
  parameter int DATA_W    = 512
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                s_axis_tx_metadata_valid,
  output logic                s_axis_tx_metadata_ready,
  input  logic [47:0]         s_axis_tx_metadata_data,
  input  logic                s_axis_tx_data_valid,
  output logic                s_axis_tx_data_ready,
  input  logic [DATA_W-1:0]   s_axis_tx_data_data,
  input  logic [DATA_W/8-1:0] s_axis_tx_data_keep,
  input  logic                s_axis_tx_data_last,
  output logic                m_axis_tx_status_valid,
  input  logic                m_axis_tx_status_ready,
  output logic [63:0]         m_axis_tx_status_data,
  output logic                m_axis_tx_metadata_valid,
  input  logic                m_axis_tx_metadata_ready,
  output logic [31:0]         m_axis_tx_metadata_data,
  output logic                m_axis_tx_data_valid,
  input  logic                m_axis_tx_data_ready,
  output logic [DATA_W-1:0]   m_axis_tx_data_data,
  output logic [DATA_W/8-1:0] m_axis_tx_data_keep,
  output logic                m_axis_tx_data_last,
  input  logic                s_axis_tx_status_valid,
  output logic                s_axis_tx_status_ready,
  input  logic [63:0]         s_axis_tx_status_data
);

  logic [2:0]             state;
  logic [2:0]             state_nxt;
  logic [SESSION_W-1:0]   session;
  logic [LEN_W-1:0]       total_len;
  logic [LEN_W-1:0]       remaining;
  logic [LEN_W-1:0]       remaining_nxt;
  logic [CHUNK_LEN_W-1:0] chunk;
  logic [CHUNK_LEN_W:0]   chunk_ceil;
  logic [BEAT_CNT_W-1:0]  beats;
  logic [BEAT_CNT_W-1:0]  beat_cnt;
  logic                   meta_rdy;
  logic                   req_hs;
  logic                   meta_hs;
  logic                   data_hs;
  logic                   sts_out_hs;
  logic                   last_beat;
  logic                   all_acked;
  logic [ERR_W-1:0]       err;
  req_t                   req;
  meta_t                  meta;
  sts_t                   sts;
  logic                   unused_inputs;

  assign unused_inputs = ^{s_axis_tx_data_keep, s_axis_tx_data_last, s_axis_tx_status_data[61:0]};

  assign req           = req_t'(s_axis_tx_metadata_data);
  assign chunk         = (remaining < LEN_W'(CHUNK_LEN)) ? remaining[CHUNK_LEN_W-1:0]
                                                         : CHUNK_LEN_W'(CHUNK_LEN);
  assign chunk_ceil    = {1'b0, chunk} + (CHUNK_LEN_W+1)'(BEAT_BYTES - 1);
  assign beats         = chunk_ceil[CHUNK_LEN_W:6];
  assign remaining_nxt = remaining - LEN_W'(chunk);
  assign last_beat     = (beat_cnt == beats - 1'b1);

  // meta_rdy is registered so the request port stays closed while reset is asserted.
  assign s_axis_tx_metadata_ready = meta_rdy;
  assign req_hs = s_axis_tx_metadata_valid && meta_rdy;

  assign meta.len                 = chunk;
  assign meta.session             = session;
  assign m_axis_tx_metadata_valid = (state == ST_META);
  assign m_axis_tx_metadata_data  = meta;
  assign meta_hs = m_axis_tx_metadata_valid && m_axis_tx_metadata_ready;

  assign m_axis_tx_data_valid = (state == ST_DATA) && s_axis_tx_data_valid;
  assign s_axis_tx_data_ready = (state == ST_DATA) && m_axis_tx_data_ready;
  assign m_axis_tx_data_data  = s_axis_tx_data_data;
  assign m_axis_tx_data_last  = (state == ST_DATA) && last_beat;
  assign m_axis_tx_data_keep  = last_beat ? keep_mask(chunk[5:0]) : '1;
  assign data_hs = m_axis_tx_data_valid && m_axis_tx_data_ready;

  assign sts.err                = err;
  assign sts.rsvd               = '0;
  assign sts.len                = total_len;
  assign sts.session            = session;
  assign m_axis_tx_status_valid = (state == ST_STATUS);
  assign m_axis_tx_status_data  = sts;
  assign sts_out_hs = m_axis_tx_status_valid && m_axis_tx_status_ready;

  tx_split_status_agg u_status_agg (
    .clk       (clk),
    .rstn      (rstn),
    .clear     (req_hs),
    .issue     (meta_hs),
    .active    (state != ST_IDLE),
    .sts_valid (s_axis_tx_status_valid),
    .sts_err   (s_axis_tx_status_data[63:62]),
    .sts_ready (s_axis_tx_status_ready),
    .all_acked (all_acked),
    .err       (err)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (req_hs) state_nxt = (req.len == '0) ? ST_STATUS : ST_META;
      ST_META:   if (meta_hs) state_nxt = ST_DATA;
      ST_DATA:   if (data_hs && last_beat) state_nxt = (remaining_nxt != '0) ? ST_META : ST_WAIT;
      ST_WAIT:   if (all_acked) state_nxt = ST_STATUS;
      ST_STATUS: if (sts_out_hs) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      meta_rdy  <= 1'b0;
      session   <= '0;
      total_len <= '0;
      remaining <= '0;
      beat_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      meta_rdy <= (state_nxt == ST_IDLE);
      if (req_hs) begin
        session   <= req.session;
        total_len <= req.len;
        remaining <= req.len;
      end
      if (meta_hs) begin
        beat_cnt <= '0;
      end
      if (data_hs) begin
        if (last_beat) begin
          beat_cnt  <= '0;
          remaining <= remaining_nxt;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tx_data_split.sv
// Randomized bench for tx_data_split with a queue-based chunking model and per-chunk status responder.
module tb_tx_data_split;

  localparam int CL = 4096;

  typedef struct packed {
    logic        last;
    logic [63:0] keep;
  } beat_t;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         s_axis_tx_metadata_valid;
  logic         s_axis_tx_metadata_ready;
  logic [47:0]  s_axis_tx_metadata_data;
  logic         s_axis_tx_data_valid;
  logic         s_axis_tx_data_ready;
  logic [511:0] s_axis_tx_data_data;
  logic [63:0]  s_axis_tx_data_keep;
  logic         s_axis_tx_data_last;
  logic         m_axis_tx_status_valid;
  logic         m_axis_tx_status_ready;
  logic [63:0]  m_axis_tx_status_data;
  logic         m_axis_tx_metadata_valid;
  logic         m_axis_tx_metadata_ready;
  logic [31:0]  m_axis_tx_metadata_data;
  logic         m_axis_tx_data_valid;
  logic         m_axis_tx_data_ready;
  logic [511:0] m_axis_tx_data_data;
  logic [63:0]  m_axis_tx_data_keep;
  logic         m_axis_tx_data_last;
  logic         s_axis_tx_status_valid;
  logic         s_axis_tx_status_ready;
  logic [63:0]  s_axis_tx_status_data;

  always #5 clk = ~clk;

  tx_data_split #(.CHUNK_LEN(CL), .DATA_W(512)) dut (
    .clk                      (clk),
    .rstn                     (rstn),
    .s_axis_tx_metadata_valid (s_axis_tx_metadata_valid),
    .s_axis_tx_metadata_ready (s_axis_tx_metadata_ready),
    .s_axis_tx_metadata_data  (s_axis_tx_metadata_data),
    .s_axis_tx_data_valid     (s_axis_tx_data_valid),
    .s_axis_tx_data_ready     (s_axis_tx_data_ready),
    .s_axis_tx_data_data      (s_axis_tx_data_data),
    .s_axis_tx_data_keep      (s_axis_tx_data_keep),
    .s_axis_tx_data_last      (s_axis_tx_data_last),
    .m_axis_tx_status_valid   (m_axis_tx_status_valid),
    .m_axis_tx_status_ready   (m_axis_tx_status_ready),
    .m_axis_tx_status_data    (m_axis_tx_status_data),
    .m_axis_tx_metadata_valid (m_axis_tx_metadata_valid),
    .m_axis_tx_metadata_ready (m_axis_tx_metadata_ready),
    .m_axis_tx_metadata_data  (m_axis_tx_metadata_data),
    .m_axis_tx_data_valid     (m_axis_tx_data_valid),
    .m_axis_tx_data_ready     (m_axis_tx_data_ready),
    .m_axis_tx_data_data      (m_axis_tx_data_data),
    .m_axis_tx_data_keep      (m_axis_tx_data_keep),
    .m_axis_tx_data_last      (m_axis_tx_data_last),
    .s_axis_tx_status_valid   (s_axis_tx_status_valid),
    .s_axis_tx_status_ready   (s_axis_tx_status_ready),
    .s_axis_tx_status_data    (s_axis_tx_status_data)
  );

  int          total = 0;
  int          bad = 0;
  int          mode = 0;
  int          flush_req = 0;
  int          beats_total = 0;
  int          st_issued = 0;
  int          st_acked = 0;
  logic [47:0] req_q[$];
  logic [31:0] exp_meta_q[$];
  beat_t       exp_beat_q[$];
  logic [63:0] exp_sts_q[$];
  logic [1:0]  sts_err_q[$];
  logic        smeta_hs = 1'b0;
  logic        sdata_hs = 1'b0;
  logic        ssts_hs = 1'b0;
  logic        mmeta_hs, mdata_hs, msts_hs;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected chunk metas, beat last/keep and the aggregated status, straight from the length rules.
  task automatic add_req(input logic [31:0] len, input logic [15:0] sess, input int err_chunk);
    logic [31:0] rem;
    logic [1:0]  agg;
    logic [1:0]  e;
    int          c;
    int          nb;
    int          idx;
    beat_t       bt;
    rem = len;
    agg = 2'b00;
    idx = 0;
    while (rem != 0) begin
      c  = (rem < 32'(CL)) ? int'(rem) : CL;
      nb = (c + 63) / 64;
      exp_meta_q.push_back({16'(c), sess});
      for (int b = 0; b < nb; b++) begin
        bt.last = (b == nb - 1);
        bt.keep = (bt.last && (c % 64) != 0) ? ((64'd1 << (c % 64)) - 64'd1) : {64{1'b1}};
        exp_beat_q.push_back(bt);
      end
      if (err_chunk == idx)     e = 2'b01;
      else if (err_chunk == -2) e = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      else                      e = 2'b00;
      sts_err_q.push_back(e);
      agg = agg | e;
      rem = rem - 32'(c);
      idx++;
    end
    exp_sts_q.push_back({agg, 14'd0, len, sess});
    req_q.push_back({len, sess});
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while ((exp_sts_q.size() != 0) && (n < budget)) begin
      @(posedge clk);
      n++;
    end
    chk("done_sts", 512'(exp_sts_q.size()), 512'(0));
    chk("done_beats", 512'(exp_beat_q.size()), 512'(0));
  endtask

  // Driver: updates all bench-side inputs 1 time unit after each rising edge.
  initial begin
    int flush_seen;
    logic [511:0] d;
    flush_seen = 0;
    s_axis_tx_metadata_valid = 1'b0;
    s_axis_tx_metadata_data  = '0;
    s_axis_tx_data_valid     = 1'b0;
    s_axis_tx_data_data      = '0;
    s_axis_tx_data_keep      = '0;
    s_axis_tx_data_last      = 1'b0;
    s_axis_tx_status_valid   = 1'b0;
    s_axis_tx_status_data    = '0;
    m_axis_tx_status_ready   = 1'b0;
    m_axis_tx_metadata_ready = 1'b0;
    m_axis_tx_data_ready     = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (flush_seen != flush_req) begin
        flush_seen = flush_req;
        s_axis_tx_metadata_valid = 1'b0;
        s_axis_tx_status_valid   = 1'b0;
      end
      if (smeta_hs) s_axis_tx_metadata_valid = 1'b0;
      if (!s_axis_tx_metadata_valid && req_q.size() > 0 && (mode == 0 || $urandom_range(0, 1) == 1)) begin
        s_axis_tx_metadata_valid = 1'b1;
        s_axis_tx_metadata_data  = req_q[0];
      end
      if (sdata_hs || !s_axis_tx_data_valid) begin
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
        s_axis_tx_data_data = (mode == 0) ? 512'd1234 : d;
      end
      s_axis_tx_data_valid = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      s_axis_tx_data_keep  = {$urandom, $urandom};
      s_axis_tx_data_last  = 1'($urandom_range(0, 1));
      if (ssts_hs) s_axis_tx_status_valid = 1'b0;
      if (!s_axis_tx_status_valid && st_issued > st_acked && sts_err_q.size() > 0 &&
          (mode == 0 || $urandom_range(0, 3) == 0)) begin
        s_axis_tx_status_valid = 1'b1;
        s_axis_tx_status_data  = {sts_err_q[0], (mode == 0) ? 62'd0 : 62'({$urandom, $urandom})};
      end
      m_axis_tx_metadata_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      m_axis_tx_data_ready     = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      m_axis_tx_status_ready   = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  // Monitor: on the falling edge, sees what the next rising edge will transfer.
  initial begin
    int    mon_flush;
    beat_t bt;
    mon_flush = 0;
    forever begin
      @(negedge clk);
      smeta_hs = s_axis_tx_metadata_valid && s_axis_tx_metadata_ready;
      sdata_hs = s_axis_tx_data_valid && s_axis_tx_data_ready;
      ssts_hs  = s_axis_tx_status_valid && s_axis_tx_status_ready;
      mmeta_hs = m_axis_tx_metadata_valid && m_axis_tx_metadata_ready;
      mdata_hs = m_axis_tx_data_valid && m_axis_tx_data_ready;
      msts_hs  = m_axis_tx_status_valid && m_axis_tx_status_ready;
      if (mon_flush != flush_req) begin
        mon_flush = flush_req;
        req_q.delete();
        exp_meta_q.delete();
        exp_beat_q.delete();
        exp_sts_q.delete();
        sts_err_q.delete();
        st_issued = 0;
        st_acked  = 0;
      end
      if (rstn) begin
        chk("sts_rdy", 512'(s_axis_tx_status_ready), 512'(st_acked < st_issued));
        if (m_axis_tx_metadata_valid) chk("dat_rdy_in_meta", 512'(s_axis_tx_data_ready), 512'(0));
        if (m_axis_tx_data_valid) begin
          chk("dat_rdy_pass", 512'(s_axis_tx_data_ready), 512'(m_axis_tx_data_ready));
          chk("dat_pass", m_axis_tx_data_data, s_axis_tx_data_data);
        end
        if (mdata_hs) begin
          beats_total++;
          if (exp_beat_q.size() == 0) begin
            chk("beat_extra", 512'(exp_beat_q.size()), 512'(1));
          end else begin
            bt = exp_beat_q.pop_front();
            chk("last", 512'(m_axis_tx_data_last), 512'(bt.last));
            chk("keep", 512'(m_axis_tx_data_keep), 512'(bt.keep));
          end
        end
        if (mmeta_hs) begin
          if (exp_meta_q.size() == 0) chk("meta_extra", 512'(exp_meta_q.size()), 512'(1));
          else chk("meta", 512'(m_axis_tx_metadata_data), 512'(exp_meta_q.pop_front()));
        end
        if (msts_hs) begin
          chk("sts_after_acks", 512'(st_acked), 512'(st_issued));
          if (exp_sts_q.size() == 0) chk("sts_extra", 512'(exp_sts_q.size()), 512'(1));
          else chk("status", 512'(m_axis_tx_status_data), 512'(exp_sts_q.pop_front()));
        end
      end
      if (smeta_hs && req_q.size() > 0) void'(req_q.pop_front());
      if (mmeta_hs) st_issued++;
      if (ssts_hs) begin
        st_acked++;
        if (sts_err_q.size() > 0) void'(sts_err_q.pop_front());
      end
    end
  end

  initial begin
    int          base;
    int          n;
    logic [31:0] len;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_meta_rdy", 512'(s_axis_tx_metadata_ready), 512'(0));
    chk("rst_dat_rdy", 512'(s_axis_tx_data_ready), 512'(0));
    chk("rst_sts_rdy", 512'(s_axis_tx_status_ready), 512'(0));
    chk("rst_meta_vld", 512'(m_axis_tx_metadata_valid), 512'(0));
    chk("rst_dat_vld", 512'(m_axis_tx_data_valid), 512'(0));
    chk("rst_sts_vld", 512'(m_axis_tx_status_valid), 512'(0));
    rstn = 1'b1;

    mode = 0;
    add_req(32'h40000, 16'h0, -1);
    wait_done(20000);
    add_req(32'd100, 16'd7, -1);
    wait_done(500);
    add_req(32'(CL + 1), 16'h55, -1);
    wait_done(1000);

    mode = 1;
    add_req(32'(5 * CL + 100), 16'd3, 2);
    wait_done(8000);
    for (int r = 0; r < 12; r++) begin
      case ($urandom_range(0, 4))
        0:       len = 32'd0;
        1:       len = 32'(64 * $urandom_range(1, 80));
        2:       len = 32'($urandom_range(1, 200));
        default: len = 32'($urandom_range(1, 3 * CL + 300));
      endcase
      add_req(len, 16'($urandom), -2);
    end
    wait_done(40000);

    base = beats_total;
    add_req(32'(3 * CL), 16'd9, -1);
    n = 0;
    while ((beats_total - base < 10) && (n < 3000)) begin
      @(posedge clk);
      n++;
    end
    chk("mid_data_reached", 512'(beats_total - base >= 10), 512'(1));
    @(posedge clk);
    #3;
    rstn = 1'b0;
    flush_req++;
    #1;
    chk("arst_dat_vld", 512'(m_axis_tx_data_valid), 512'(0));
    chk("arst_meta_vld", 512'(m_axis_tx_metadata_valid), 512'(0));
    chk("arst_sts_vld", 512'(m_axis_tx_status_valid), 512'(0));
    chk("arst_dat_rdy", 512'(s_axis_tx_data_ready), 512'(0));
    chk("arst_meta_rdy", 512'(s_axis_tx_metadata_ready), 512'(0));
    chk("arst_sts_rdy", 512'(s_axis_tx_status_ready), 512'(0));
    repeat (2) @(posedge clk);
    #2;
    rstn = 1'b1;
    add_req(32'd200, 16'd11, -1);
    wait_done(2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
